// File: rtl/dz_scan_multi.sv
`default_nettype none
// ============================================================================
// Module      : dz_scan_multi
// Description : 8x8 bicolour (red/green) LED dot-matrix scan driver. Shows
//               digits 0-9 from an internal glyph ROM in off/red/green/yellow,
//               with a programmable row-scan divider, anti-ghost blanking at
//               the start of every row slot, tear-free frame-boundary updates
//               and optional blinking.
// Ports       : clk         - system clock
//               rst         - synchronous active-low reset
//               num         - digit to show (0-9 glyphs, 10-15 blank)
//               color       - 00 off, 01 red, 10 green, 11 yellow
//               blink_en    - enables blinking
//               num_valid   - single-cycle strobe capturing num/color
//               row         - one-hot row select (polarity per ROW_ACTIVE_LOW)
//               colr/colg   - red/green columns, bit 7 = leftmost, 1 = lit
//               frame_start - one-cycle pulse at the start of the row-0 slot
// Revision    : 1.0 - initial release
// ============================================================================
module dz_scan_multi #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYC      = 16,
  parameter int BLINK_FRAMES   = 32,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] num,
  input  logic [1:0] color,
  input  logic       blink_en,
  input  logic       num_valid,
  output logic [7:0] row,
  output logic [7:0] colr,
  output logic [7:0] colg,
  output logic       frame_start
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  // Glyph ROM: row 0 is the most significant byte of each 64-bit constant.
  function automatic logic [7:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
    logic [63:0] g;
    logic [63:0] s;
    case (d)
      4'd0:    g = 64'h00_3C_66_66_66_66_66_3C;
      4'd1:    g = 64'h00_18_18_38_18_18_18_7E;
      4'd2:    g = 64'h00_3C_66_06_0C_30_60_7E;
      4'd3:    g = 64'h00_3C_66_06_1C_06_66_3C;
      4'd4:    g = 64'h00_0C_1C_2C_4C_7E_0C_0C;
      4'd5:    g = 64'h00_7E_60_7C_06_06_66_3C;
      4'd6:    g = 64'h00_3C_60_7C_66_66_66_3C;
      4'd7:    g = 64'h00_7E_06_0C_18_30_30_30;
      4'd8:    g = 64'h00_3C_66_66_3C_66_66_3C;
      4'd9:    g = 64'h00_3C_66_66_3E_06_66_3C;
      default: g = 64'h0;
    endcase
    s = g << {r, 3'b000};
    return s[63:56];
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       row_idx;
  logic [FRM_W-1:0] frame_cnt;
  logic             blink_phase;
  logic [3:0]       pend_num;
  logic [1:0]       pend_col;
  logic [3:0]       disp_num;
  logic [1:0]       disp_col;
  logic [7:0]       row_q;

  logic             div_wrap;
  logic             frame_end;
  logic             dark;
  logic [7:0]       glyph;

  always_comb begin
    div_wrap  = (div_cnt == DIV_LAST);
    frame_end = div_wrap && (row_idx == 3'd7);
    // Columns go dark during the anti-ghost window and the blink-off phase;
    // the row select itself stays driven.
    dark      = (div_cnt < BLANK_END) || (blink_en && blink_phase);
    glyph     = glyph_row(disp_num, row_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt     <= '0;
      row_idx     <= 3'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      pend_num    <= 4'hF;
      pend_col    <= 2'b00;
      disp_num    <= 4'hF;
      disp_col    <= 2'b00;
      row_q       <= 8'h00;
      colr        <= 8'h00;
      colg        <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt <= '0;
        row_idx <= row_idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (num_valid) begin
        pend_num <= num;
        pend_col <= color;
      end

      if (frame_end) begin
        // A strobe landing on the boundary itself bypasses the pending
        // register so it is not delayed by a whole frame.
        if (num_valid) begin
          disp_num <= num;
          disp_col <= color;
        end else begin
          disp_num <= pend_num;
          disp_col <= pend_col;
        end
        if (frame_cnt == FRM_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end

      row_q       <= 8'b0000_0001 << row_idx;
      colr        <= (!dark && disp_col[0]) ? glyph : 8'h00;
      colg        <= (!dark && disp_col[1]) ? glyph : 8'h00;
      frame_start <= (row_idx == 3'd0) && (div_cnt == '0);
    end
  end

  generate
    if (ROW_ACTIVE_LOW) begin : g_row_low
      assign row = ~row_q;
    end else begin : g_row_high
      assign row = row_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dz_scan_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_dz_scan_multi
// Description : Self-checking bench for dz_scan_multi. A frame-level model
//               predicts every output cycle from absolute time since reset
//               release and the history of strobes; directed literal checks
//               pin specific cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dz_scan_multi;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYC    = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = SCAN_DIV * 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] num = 4'd0;
  logic [1:0] color = 2'b00;
  logic       blink_en = 1'b0;
  logic       num_valid = 1'b0;
  logic [7:0] row, colr, colg, row_al, colr_al, colg_al;
  logic       frame_start, frame_start_al;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dz_scan_multi #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
                  .BLINK_FRAMES(BLINK_FRAMES), .ROW_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .num(num), .color(color), .blink_en(blink_en),
    .num_valid(num_valid), .row(row), .colr(colr), .colg(colg),
    .frame_start(frame_start));

  dz_scan_multi #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC),
                  .BLINK_FRAMES(BLINK_FRAMES), .ROW_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .num(num), .color(color), .blink_en(blink_en),
    .num_valid(num_valid), .row(row_al), .colr(colr_al), .colg(colg_al),
    .frame_start(frame_start_al));

  // Glyph table, digit x row.
  byte unsigned rom [10][8] = '{
    '{8'h00,8'h3C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C},
    '{8'h00,8'h18,8'h18,8'h38,8'h18,8'h18,8'h18,8'h7E},
    '{8'h00,8'h3C,8'h66,8'h06,8'h0C,8'h30,8'h60,8'h7E},
    '{8'h00,8'h3C,8'h66,8'h06,8'h1C,8'h06,8'h66,8'h3C},
    '{8'h00,8'h0C,8'h1C,8'h2C,8'h4C,8'h7E,8'h0C,8'h0C},
    '{8'h00,8'h7E,8'h60,8'h7C,8'h06,8'h06,8'h66,8'h3C},
    '{8'h00,8'h3C,8'h60,8'h7C,8'h66,8'h66,8'h66,8'h3C},
    '{8'h00,8'h7E,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30},
    '{8'h00,8'h3C,8'h66,8'h66,8'h3C,8'h66,8'h66,8'h3C},
    '{8'h00,8'h3C,8'h66,8'h66,8'h3E,8'h06,8'h66,8'h3C}
  };

  // Model history: cycle index since release, strobes and blink enables.
  typedef struct { int idx; logic [3:0] n; logic [1:0] c; } strobe_t;
  strobe_t strobes[$];
  logic    ben [2048];
  int      st = 0;      // next cycle index to be consumed
  int      out_k = 0;   // cycle index the current outputs belong to
  int      mode = 0;    // 0 none, 1 reset outputs, 2 scanning outputs

  always @(posedge clk) begin
    if (!rst) begin
      st   = 0;
      mode = 1;
      strobes.delete();
    end else begin
      ben[st % 2048] = blink_en;
      if (num_valid) strobes.push_back('{st, num, color});
      out_k = st;
      mode  = 2;
      st    = st + 1;
    end
  end

  // Every-cycle comparison against the frame-level model.
  always @(negedge clk) begin
    logic [7:0] e_row, e_r, e_g, gl;
    logic       e_fs, lit;
    logic [3:0] dn;
    logic [1:0] dc;
    int f, r, d;
    if (mode == 1) begin
      checks++;
      if (row !== 8'h00 || row_al !== 8'hFF || colr !== 8'h00 || colg !== 8'h00 ||
          frame_start !== 1'b0 || colr_al !== 8'h00 || colg_al !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs: row=%h row_al=%h colr=%h colg=%h fs=%b, need 00 FF 00 00 0",
                 row, row_al, colr, colg, frame_start);
      end
    end else if (mode == 2) begin
      f  = out_k / FRAME_CYC;
      r  = (out_k / SCAN_DIV) % 8;
      d  = out_k % SCAN_DIV;
      dn = 4'hF;
      dc = 2'b00;
      // Digit shown in frame f is the last strobe taken before that frame began.
      foreach (strobes[i]) if (strobes[i].idx < f * FRAME_CYC) begin
        dn = strobes[i].n;
        dc = strobes[i].c;
      end
      gl    = (dn <= 4'd9) ? 8'(rom[dn][r]) : 8'h00;
      lit   = (d >= BLANK_CYC) && !(ben[out_k % 2048] && (((f / BLINK_FRAMES) % 2) == 1));
      e_row = 8'h01 << r;
      e_r   = (lit && dc[0]) ? gl : 8'h00;
      e_g   = (lit && dc[1]) ? gl : 8'h00;
      e_fs  = (out_k % FRAME_CYC) == 0;
      checks++;
      if (row !== e_row || row_al !== ~e_row || colr !== e_r || colg !== e_g ||
          frame_start !== e_fs || frame_start_al !== e_fs || colr_al !== e_r || colg_al !== e_g) begin
        errors++;
        $display("FAIL scan k=%0d: row=%h row_al=%h colr=%h colg=%h fs=%b, need row=%h row_al=%h colr=%h colg=%h fs=%b",
                 out_k, row, row_al, colr, colg, frame_start, e_row, ~e_row, e_r, e_g, e_fs);
      end
    end
  end

  // Wait (bounded) until the outputs on a negedge belong to cycle index k.
  task automatic wait_idx(input int k);
    for (int i = 0; i < 4000; i++) begin
      if (mode == 2 && out_k == k) return;
      @(negedge clk);
    end
    errors++;
    $display("FAIL wait_idx: index %0d never reached (now %0d)", k, out_k);
  endtask

  // Wait (bounded) until the next posedge will consume cycle index k.
  task automatic wait_st(input int k);
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (st == k) return;
    end
    errors++;
    $display("FAIL wait_st: index %0d never reached (now %0d)", k, st);
  endtask

  task automatic strobe_at(input int k, input logic [3:0] n, input logic [1:0] c);
    wait_st(k);
    num       = n;
    color     = c;
    num_valid = 1'b1;
    @(posedge clk);
    #1;
    num_valid = 1'b0;
  endtask

  task automatic lit_chk(input string name, input int k, input logic [7:0] e_row,
                         input logic [7:0] e_r, input logic [7:0] e_g, input logic e_fs);
    wait_idx(k);
    checks++;
    if (row !== e_row || colr !== e_r || colg !== e_g || frame_start !== e_fs) begin
      errors++;
      $display("FAIL %s: row=%h colr=%h colg=%h fs=%b, need row=%h colr=%h colg=%h fs=%b",
               name, row, colr, colg, frame_start, e_row, e_r, e_g, e_fs);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (row !== 8'h00 || row_al !== 8'hFF || colr !== 8'h00 || colg !== 8'h00 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL lit_reset: row=%h row_al=%h colr=%h colg=%h fs=%b, need 00 FF 00 00 0",
               row, row_al, colr, colg, frame_start);
    end
    rst = 1'b1;

    lit_chk("first_frame_start", 0, 8'h01, 8'h00, 8'h00, 1'b1);
    checks++;
    if (row_al !== 8'hFE) begin
      errors++;
      $display("FAIL row_active_low: row_al=%h, need FE", row_al);
    end
    lit_chk("no_pulse_after", 1, 8'h01, 8'h00, 8'h00, 1'b0);
    strobe_at(5, 4'd2, 2'b11);
    lit_chk("second_frame_start", 32, 8'h01, 8'h00, 8'h00, 1'b1);
    lit_chk("digit2_row7_blank", 60, 8'h80, 8'h00, 8'h00, 1'b0);
    lit_chk("digit2_row7_lit", 61, 8'h80, 8'h7E, 8'h7E, 1'b0);
    lit_chk("digit2_row7_last", 63, 8'h80, 8'h7E, 8'h7E, 1'b0);

    strobe_at(70, 4'd4, 2'b01);
    lit_chk("digit4_red_row5", 117, 8'h20, 8'h7E, 8'h00, 1'b0);
    strobe_at(130, 4'd12, 2'b11);
    lit_chk("blank_glyph_row3", 173, 8'h08, 8'h00, 8'h00, 1'b0);

    strobe_at(194, 4'd5, 2'b11);
    strobe_at(236, 4'd8, 2'b11);
    lit_chk("tearfree_old_row5", 245, 8'h20, 8'h06, 8'h06, 1'b0);
    lit_chk("tearfree_new_row5", 277, 8'h20, 8'h66, 8'h66, 1'b0);

    strobe_at(287, 4'd1, 2'b10);
    lit_chk("bypass_row1", 293, 8'h02, 8'h00, 8'h18, 1'b0);

    wait_st(300);
    blink_en = 1'b1;
    lit_chk("blink_dark", 325, 8'h02, 8'h00, 8'h00, 1'b0);
    lit_chk("blink_lit", 389, 8'h02, 8'h00, 8'h18, 1'b0);
    wait_st(450);
    blink_en = 1'b0;
    lit_chk("blink_off_visible", 485, 8'h02, 8'h00, 8'h18, 1'b0);

    // Reset in the middle of a frame; pending/displayed must be discarded.
    wait_st(530);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    lit_chk("post_reset_start", 0, 8'h01, 8'h00, 8'h00, 1'b1);
    lit_chk("post_reset_blank", 37, 8'h02, 8'h00, 8'h00, 1'b0);
    wait_idx(70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
